// File: rtl/uptimer.sv
// uptimer: count-up elapsed-time timer with prescaler, compare match and overflow.
//
// The counter advances one tick every PERIOD clocks while running (PERIOD 0 or 1
// means one tick per clock). A non-zero compare value sets a sticky match flag
// and produces a one-cycle match_pulse on the tick that reaches it. Wrap from
// all-ones to zero sets a sticky overflow flag.
//
// Optional feature: define UPTIMER_AUTORELOAD_EN for periodic mode, where a
// matching tick reloads the counter with 0 instead of the compare value.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   start        enter RUN (stop has priority)
//   stop         enter IDLE, prescaler phase kept
//   clear        zero counter, prescaler, match, match_pulse, overflow
//   cmp_load     load cmp_data into compare, clear match
//   cmp_data     compare value (0 disables matching)
//   counter      elapsed ticks
//   running      1 while in RUN
//   match        sticky compare match
//   match_pulse  one-cycle pulse on the matching tick
//   overflow     sticky counter wrap flag
module uptimer #(
    parameter int unsigned PERIOD = 27_000,
    parameter int unsigned WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             cmp_load,
    input  logic [WIDTH-1:0] cmp_data,
    output logic [WIDTH-1:0] counter,
    output logic             running,
    output logic             match,
    output logic             match_pulse,
    output logic             overflow
);

    localparam int unsigned PW = 16;
    // One extra bit so prescaler + 1 never wraps before the PERIOD compare.
    localparam logic [PW:0] PERIOD_X = (PW + 1)'(PERIOD);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]    prescaler, prescaler_nxt;
    logic [PW:0]      inc;
    logic [WIDTH-1:0] compare, compare_nxt;
    logic [WIDTH-1:0] counter_nxt, cnt_inc;
    logic             match_nxt, pulse_nxt, overflow_nxt;
    logic             tick, hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Next-state logic: stop wins over start
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end
    end

    // Prescaler, counter, compare and flag next values
    always_comb begin
        prescaler_nxt = prescaler;
        counter_nxt   = counter;
        compare_nxt   = compare;
        match_nxt     = match;
        pulse_nxt     = 1'b0;
        overflow_nxt  = overflow;
        tick          = 1'b0;

        inc     = {1'b0, prescaler} + (PW + 1)'(1);
        cnt_inc = counter + WIDTH'(1);
        // Uses the compare value held before any load in this cycle.
        hit     = (compare != '0) && (cnt_inc == compare);

        if (state == RUN) begin
            if (inc < PERIOD_X) begin
                prescaler_nxt = inc[PW-1:0];
            end else begin
                prescaler_nxt = '0;
                tick          = 1'b1;
            end
        end

        if (cmp_load) begin
            compare_nxt = cmp_data;
            match_nxt   = 1'b0;
        end

        // A matching tick sets match even when cmp_load clears it this cycle.
        if (tick) begin
`ifdef UPTIMER_AUTORELOAD_EN
            counter_nxt = hit ? '0 : cnt_inc;
`else
            counter_nxt = cnt_inc;
`endif
            if (&counter) begin
                overflow_nxt = 1'b1;
            end
            if (hit) begin
                match_nxt = 1'b1;
                pulse_nxt = 1'b1;
            end
        end

        // clear overrides any tick; state and compare are untouched.
        if (clear) begin
            prescaler_nxt = '0;
            counter_nxt   = '0;
            match_nxt     = 1'b0;
            pulse_nxt     = 1'b0;
            overflow_nxt  = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            counter     <= '0;
            compare     <= '0;
            match       <= 1'b0;
            match_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prescaler   <= prescaler_nxt;
            counter     <= counter_nxt;
            compare     <= compare_nxt;
            match       <= match_nxt;
            match_pulse <= pulse_nxt;
            overflow    <= overflow_nxt;
        end
    end

endmodule

// File: doc/uptimer.md
Name: uptimer

Overview:
Count-up elapsed-time timer, the up-counting counterpart of the countdown timer block. The CPU starts, stops and clears it, and reads the elapsed count in units of PERIOD clocks. A programmable compare value raises a sticky match flag and a one-cycle match pulse for the interrupt controller. Counter wrap-around is flagged as overflow.

Parameters:
PERIOD, 27_000, clocks per count tick; 0 <= PERIOD <= 65535; 0 and 1 both mean one tick per clock.
WIDTH, 16, counter and compare width.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  enter RUN at clk rising edge
stop  input  1  enter IDLE at clk rising edge; prescaler phase is kept
clear  input  1  zero counter, prescaler, match and overflow
cmp_load  input  1  load cmp_data into the compare register
cmp_data  input  WIDTH  compare value; 0 disables matching
counter  output  WIDTH  elapsed ticks
running  output  1  1 while in RUN
match  output  1  sticky: counter reached compare
match_pulse  output  1  one-cycle pulse on the tick that sets match
overflow  output  1  sticky: counter wrapped from all-ones to 0

Behaviour:
- Reset values: counter=0, prescaler=0, compare=0, state IDLE, running=0, match=0, match_pulse=0, overflow=0.
- State machine has two states, IDLE and RUN. running is a registered output and equals (state==RUN).
- IDLE to RUN on start. RUN to IDLE on stop. If start and stop are both 1, stop wins.
- Prescaler is a 16-bit register; inc = prescaler + 1.
- In RUN: if inc < PERIOD, prescaler <= inc. Otherwise prescaler <= 0 and a tick occurs.
- In IDLE: prescaler and counter hold.
- Tick: counter <= counter + 1, modulo 2^WIDTH.
  - If the old counter is all-ones, overflow <= 1.
  - If compare != 0 and (counter + 1) == compare, match <= 1 and match_pulse <= 1 for that single cycle.
- match_pulse is 0 on every cycle without a matching tick.
- Latency: with prescaler=0 at the start edge, the first increment appears PERIOD clocks after the edge that samples start (1 clock when PERIOD <= 1). counter is registered.
- clear:
  - Sets counter=0, prescaler=0, match=0, match_pulse=0, overflow=0.
  - Does not change state or compare.
  - Overrides any tick in the same cycle.
  - clear together with start: counters zeroed and RUN entered. Counting then proceeds from 0 with full PERIOD latency.
- cmp_load:
  - Sets compare <= cmp_data and clears match.
  - A tick in the same cycle is compared against the old compare value.
  - If that tick matches, match is set; the set takes priority over the clear.
- Compare is never checked against the current count at load time. Only ticks can set match.
- match and overflow stay set until clear, reset, or (match only) cmp_load.
- Reset asserted mid-run forces all reset values immediately, asynchronously.

Optional Feature:
Macro: UPTIMER_AUTORELOAD_EN.
- Defined: periodic mode. On a matching tick the counter becomes 0 instead of compare; match and match_pulse are set as normal. With compare != 0 the counter therefore never overflows, and match_pulse fires every compare*PERIOD clocks.
- Not defined: the counter continues past compare up to wrap-around. match_pulse fires once per pass through compare.

Test Plan:
1. PERIOD=4, reset, start pulse -> running=1 next cycle; counter=1 at 4 clocks after the start edge, counter=3 at 12 clocks.
2. PERIOD=4, run 6 clocks, stop for 10 clocks, start again -> counter holds at 1 while stopped; counter=2 two clocks after restart (prescaler phase kept).
3. PERIOD=1, cmp_load with 5, start -> match_pulse high exactly 1 cycle as counter becomes 5. match stays 1. Without the macro counter=6 next cycle; with UPTIMER_AUTORELOAD_EN counter=0, and the pulse repeats every 5 clocks.
4. WIDTH=4, PERIOD=1, run 16 clocks -> counter wraps 15 to 0 and overflow=1. clear -> counter=0, overflow=0, running stays 1.
5. start and stop in the same cycle from IDLE -> running stays 0. clear together with start at counter=7 -> counter=0, running=1.
6. Async rst mid-run with match=1 -> all outputs 0 without waiting for a clk edge; compare resets to 0, so no later match occurs until cmp_load.
